// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, payload struct and helpers for the CDB arbiter slice.
// Optional starvation checker is enabled by defining CDB_STARVE_CHK_EN.
package cdb_arbiter_pkg;

    localparam int FU_NUM     = 8;
    localparam int WORD_SIZE  = 32;
    localparam int RB_SIZE    = 16;
    localparam int RB_INDEX   = 4;
    localparam int STARVE_LIM = 64;
    localparam int FU_INDEX   = $clog2(FU_NUM);

    localparam logic [FU_NUM-1:0] NO_FU = '0;

    typedef logic [FU_INDEX-1:0] fu_idx_t;

    typedef struct packed {
        logic [RB_INDEX-1:0]  rbindex;
        logic [WORD_SIZE-1:0] data;
        logic [WORD_SIZE-1:0] addr;
    } fu_result_t;

    function automatic fu_idx_t onehot_to_idx(input logic [FU_NUM-1:0] oh);
        fu_idx_t idx;
        idx = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            if (oh[i]) idx = fu_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU request/grant handshake plus the slotted CDB bus toward the reorder buffer.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic [FU_NUM-1:0]           req;
    logic [FU_NUM*RB_INDEX-1:0]  req_rbindex;
    logic [FU_NUM*WORD_SIZE-1:0] req_data;
    logic [FU_NUM*WORD_SIZE-1:0] req_addr;
    logic [FU_NUM-1:0]           flush;
    logic [FU_NUM-1:0]           grant;
    logic [RB_SIZE-1:0]          CDB_data_valid;
    logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data;
    logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_addr;
    logic [FU_NUM-1:0]           cdb_fu;
    logic                        starve_err;

    modport slave (
        input  req, req_rbindex, req_data, req_addr, flush,
        output grant, CDB_data_valid, CDB_data_data, CDB_data_addr, cdb_fu, starve_err
    );

    modport master (
        output req, req_rbindex, req_data, req_addr, flush,
        input  grant, CDB_data_valid, CDB_data_data, CDB_data_addr, cdb_fu, starve_err
    );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot first set bit of vec at or after start, wrapping.
module cdb_arbiter_rr_picker #(
    parameter int N = 8
) (
    input  logic [N-1:0]         vec,
    input  logic [$clog2(N)-1:0] start,
    output logic [N-1:0]         onehot,
    output logic                 any
);

    int   pos;
    logic found;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        pos    = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) + k;
            if (pos >= N) pos = pos - N;
            if (!found && vec[pos]) begin
                onehot[pos] = 1'b1;
                found       = 1'b1;
            end
        end
        any = |vec;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB among functional units; registers one beat per cycle.
// Defining CDB_STARVE_CHK_EN adds per-FU wait counters driving the sticky starve_err flag.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    logic [FU_NUM-1:0]            elig;
    logic [FU_NUM-1:0]            pick_oh;
    logic                         pick_any;
    logic [FU_NUM-1:0]            grant_int;
    fu_idx_t                      rr_ptr;
    fu_idx_t                      win_idx;
    fu_result_t                   win;
    logic                         slot_ok;
    logic [RB_SIZE-1:0]           valid_nxt;
    logic [RB_SIZE*WORD_SIZE-1:0] data_nxt;
    logic [RB_SIZE*WORD_SIZE-1:0] addr_nxt;

    assign elig = bus.req & ~bus.flush;

    cdb_arbiter_rr_picker #(.N(FU_NUM)) u_picker (
        .vec    (elig),
        .start  (rr_ptr),
        .onehot (pick_oh),
        .any    (pick_any)
    );

    // Grant is forced off while reset is held so no FU drops its request early.
    assign grant_int = (reset && pick_any) ? pick_oh : NO_FU;
    assign bus.grant = grant_int;
    assign win_idx   = onehot_to_idx(grant_int);

    always_comb begin
        win = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            if (grant_int[i]) begin
                win.rbindex = bus.req_rbindex[i*RB_INDEX +: RB_INDEX];
                win.data    = bus.req_data[i*WORD_SIZE +: WORD_SIZE];
                win.addr    = bus.req_addr[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign slot_ok = ({1'b0, win.rbindex} < (RB_INDEX+1)'(RB_SIZE));

    // An out-of-range slot still consumes the grant but puts nothing on the bus.
    always_comb begin
        valid_nxt = '0;
        data_nxt  = '0;
        addr_nxt  = '0;
        if ((grant_int != NO_FU) && slot_ok) begin
            valid_nxt[win.rbindex]                          = 1'b1;
            data_nxt[int'(win.rbindex)*WORD_SIZE +: WORD_SIZE] = win.data;
            addr_nxt[int'(win.rbindex)*WORD_SIZE +: WORD_SIZE] = win.addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.CDB_data_valid <= '0;
            bus.CDB_data_data  <= '0;
            bus.CDB_data_addr  <= '0;
            bus.cdb_fu         <= NO_FU;
            rr_ptr             <= '0;
        end else begin
            bus.CDB_data_valid <= valid_nxt;
            bus.CDB_data_data  <= data_nxt;
            bus.CDB_data_addr  <= addr_nxt;
            bus.cdb_fu         <= grant_int;
            if (grant_int != NO_FU) begin
                rr_ptr <= (int'(win_idx) == FU_NUM - 1) ? fu_idx_t'(0) : fu_idx_t'(win_idx + 1'b1);
            end
        end
    end

`ifdef CDB_STARVE_CHK_EN
    localparam int CNT_W = $clog2(STARVE_LIM) + 1;

    logic [FU_NUM-1:0][CNT_W-1:0] wait_cnt;
    logic                         starve_hit;
    logic                         starve_q;

    always_comb begin
        starve_hit = 1'b0;
        for (int i = 0; i < FU_NUM; i++) begin
            if (wait_cnt[i] == CNT_W'(STARVE_LIM)) starve_hit = 1'b1;
        end
    end

    // Counters saturate at the limit; the flag itself is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            starve_q <= 1'b0;
        end else begin
            for (int i = 0; i < FU_NUM; i++) begin
                if (bus.req[i] && !grant_int[i] && !bus.flush[i]) begin
                    if (wait_cnt[i] != CNT_W'(STARVE_LIM)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
            if (starve_hit) starve_q <= 1'b1;
        end
    end

    assign bus.starve_err = starve_q;
`else
    assign bus.starve_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: grants checked at issue, CDB beats checked by a monitor.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   expQ[$];
   int   rbTab[FU_NUM];
   logic [WORD_SIZE-1:0] dataTab[FU_NUM];
   logic [WORD_SIZE-1:0] addrTab[FU_NUM];

   cdb_arbiter_if bus();

   cdb_arbiter u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // 10 ns clock; stimulus on negedge, sampling one step after each edge
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [RB_SIZE*WORD_SIZE-1:0] act,
                              input logic [RB_SIZE*WORD_SIZE-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [RB_SIZE*WORD_SIZE-1:0] expBus(input int f, input bit isAddr);
      logic [RB_SIZE*WORD_SIZE-1:0] b;
      b = '0;
      b[rbTab[f]*WORD_SIZE +: WORD_SIZE] = isAddr ? addrTab[f] : dataTab[f];
      return b;
   endfunction

   // Drive one request pattern, check the combinational grant, and queue the expected beat
   task automatic applyStimulus(input logic [FU_NUM-1:0] r, input logic [FU_NUM-1:0] fl,
                                input logic [FU_NUM-1:0] expGrant, input string name);
      @(negedge clk);
      bus.req   = r;
      bus.flush = fl;
      #1;
      checkOutput(name, RB_SIZE*WORD_SIZE'(bus.grant), RB_SIZE*WORD_SIZE'(expGrant));
      for (int i = 0; i < FU_NUM; i++) begin
         if (expGrant[i]) expQ.push_back(i);
      end
   endtask

   // Monitor: any beat on the CDB must match the oldest expected grant
   initial begin
      int f;
      forever begin
         @(posedge clk);
         #1;
         if (bus.CDB_data_valid != '0 || bus.cdb_fu != '0) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_beat: got valid=%0h fu=%0h expected no beat",
                        bus.CDB_data_valid, bus.cdb_fu);
            end else begin
               f = expQ.pop_front();
               checkOutput("beat_fu", RB_SIZE*WORD_SIZE'(bus.cdb_fu), RB_SIZE*WORD_SIZE'(1) << f);
               checkOutput("beat_valid", RB_SIZE*WORD_SIZE'(bus.CDB_data_valid),
                           RB_SIZE*WORD_SIZE'(1) << rbTab[f]);
               checkOutput("beat_data", bus.CDB_data_data, expBus(f, 1'b0));
               checkOutput("beat_addr", bus.CDB_data_addr, expBus(f, 1'b1));
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < FU_NUM; i++) begin
         rbTab[i]   = i + 3;
         dataTab[i] = 32'h1232 + 32'(i);
         addrTab[i] = 32'hA000_0000 + 32'(i * 4);
         bus.req_rbindex[i*RB_INDEX +: RB_INDEX]  = RB_INDEX'(rbTab[i]);
         bus.req_data[i*WORD_SIZE +: WORD_SIZE]   = dataTab[i];
         bus.req_addr[i*WORD_SIZE +: WORD_SIZE]   = addrTab[i];
      end

      // Reset: grant gated off even with every FU requesting
      reset     = 1'b0;
      bus.req   = 8'hFF;
      bus.flush = '0;
      #1;
      checkOutput("reset_grant", RB_SIZE*WORD_SIZE'(bus.grant), '0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid", RB_SIZE*WORD_SIZE'(bus.CDB_data_valid), '0);
      checkOutput("reset_fu", RB_SIZE*WORD_SIZE'(bus.cdb_fu), '0);
      checkOutput("reset_data", bus.CDB_data_data, '0);
      checkOutput("reset_starve", RB_SIZE*WORD_SIZE'(bus.starve_err), '0);
      bus.req = '0;
      @(negedge clk);
      reset = 1'b1;

      // Full contention: strict rotation 0..7 twice
      for (int c = 0; c < 2 * FU_NUM; c++) begin
         applyStimulus(8'hFF, 8'h00, FU_NUM'(1) << (c % FU_NUM), "contention_grant");
      end

      // Single request from FU2 (slot 5, data 1234); pointer moves to 3
      applyStimulus(8'h04, 8'h00, 8'h04, "single_grant");
      applyStimulus(8'h00, 8'h00, 8'h00, "idle_grant");

      // Rotation: after FU6 wins, FU0 comes before FU6
      applyStimulus(8'h40, 8'h00, 8'h40, "rot_fu6");
      applyStimulus(8'h41, 8'h00, 8'h01, "rot_fu0_first");
      applyStimulus(8'h40, 8'h00, 8'h40, "rot_fu6_again");

      // Flush: FU0 masked, FU1 wins; a lone flushed requester gets nothing
      applyStimulus(8'h03, 8'h01, 8'h02, "flush_grant");
      applyStimulus(8'h01, 8'h01, 8'h00, "flush_only");
      applyStimulus(8'h01, 8'h00, 8'h01, "unflush_grant");

      // Reset mid-beat: outputs clear immediately
      applyStimulus(8'h80, 8'h00, 8'h80, "pre_reset_grant");
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midreset_valid", RB_SIZE*WORD_SIZE'(bus.CDB_data_valid), '0);
      checkOutput("midreset_fu", RB_SIZE*WORD_SIZE'(bus.cdb_fu), '0);
      checkOutput("midreset_data", bus.CDB_data_data, '0);
      checkOutput("midreset_addr", bus.CDB_data_addr, '0);
      checkOutput("midreset_grant", RB_SIZE*WORD_SIZE'(bus.grant), '0);
      bus.req = '0;
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(8'h80, 8'h00, 8'h80, "post_reset_fu7");
      applyStimulus(8'h00, 8'h00, 8'h00, "tail_idle");

      repeat (3) @(posedge clk);
      #2;
      checkOutput("queue_drained", RB_SIZE*WORD_SIZE'(expQ.size()), '0);
      checkOutput("starve_err", RB_SIZE*WORD_SIZE'(bus.starve_err), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
